// File: rtl/elm_batch_sequencer_if.sv
// Host, engine and result-FIFO signals of the ELM batch sequencer.
// master = host/engine environment, slave = sequencer.
interface elm_batch_sequencer_if #(
  parameter int WORD_W = 16
);
  logic              cmd_start;
  logic [3:0]        batch_len;
  logic [WORD_W-1:0] vec_word;
  logic              vec_valid;
  logic              vec_ready;
  logic              eng_start;
  logic              eng_din;
  logic              eng_din_valid;
  logic              eng_give_input;
  logic [3:0]        eng_hw_digit;
  logic              eng_output_valid;
  logic [3:0]        res_digit;
  logic [3:0]        res_idx;
  logic              res_valid;
  logic              res_ready;
  logic              busy;
  logic              done;
  logic              err_timeout;

  modport master (
    output cmd_start, batch_len, vec_word, vec_valid, eng_give_input,
           eng_hw_digit, eng_output_valid, res_ready,
    input  vec_ready, eng_start, eng_din, eng_din_valid, res_digit, res_idx,
           res_valid, busy, done, err_timeout
  );

  modport slave (
    input  cmd_start, batch_len, vec_word, vec_valid, eng_give_input,
           eng_hw_digit, eng_output_valid, res_ready,
    output vec_ready, eng_start, eng_din, eng_din_valid, res_digit, res_idx,
           res_valid, busy, done, err_timeout
  );
endinterface

// File: rtl/elm_batch_sequencer.sv
// Batch sequencer: fetches host vectors, streams them bit-serially to the
// inference engine and queues {index, digit} results in a small FIFO.
module elm_batch_sequencer #(
  parameter int VEC_BITS  = 256,
  parameter int WORD_W    = 16,
  parameter int RES_DEPTH = 8,
  parameter int TIMEOUT   = 65535
) (
  input logic            clk,
  input logic            rst,
  elm_batch_sequencer_if.slave bus
);
  localparam int NWORDS = VEC_BITS / WORD_W;
  localparam int WCW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int BCW    = $clog2(VEC_BITS);
  localparam int TCW    = $clog2(TIMEOUT + 1);
  localparam int PW     = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int CW     = $clog2(RES_DEPTH + 1);

  typedef enum logic [2:0] {IDLE, FETCH, START, FEED, WAIT, STORE, NEXT, DONE} state_t;

  state_t              state, state_nx;
  logic [VEC_BITS-1:0] sr;
  logic [WCW-1:0]      wcnt;
  logic [BCW-1:0]      bcnt;
  logic [TCW-1:0]      tcnt;
  logic [3:0]          blen, idx;
  logic [7:0]          hold;
  logic [7:0]          mem [RES_DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       cnt;
  logic                vec_ready_q, eng_start_q, eng_din_valid_q, busy_q, done_q, err_q;
  logic                accept, shift, last_word, last_bit, tmo;
  logic                fifo_full, fifo_empty, push, pop;
  logic [7:0]          head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RES_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign accept     = (state == FETCH) && bus.vec_valid && vec_ready_q;
  assign shift      = (state == FEED) && bus.eng_give_input;
  assign last_word  = (wcnt == WCW'(NWORDS - 1));
  assign last_bit   = (bcnt == BCW'(VEC_BITS - 1));
  assign tmo        = (tcnt == TCW'(TIMEOUT - 1));
  assign fifo_full  = (cnt == CW'(RES_DEPTH));
  assign fifo_empty = (cnt == '0);
  assign pop        = !fifo_empty && bus.res_ready;
  // A pop in the same cycle frees the slot, so STORE may write into a full FIFO.
  assign push       = (state == STORE) && (!fifo_full || pop);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.cmd_start && bus.batch_len != '0) state_nx = FETCH;
      FETCH:   if (accept && last_word) state_nx = START;
      START:   state_nx = FEED;
      FEED:    if (shift && last_bit) state_nx = WAIT;
      WAIT:    if (bus.eng_output_valid) state_nx = STORE;
               else if (tmo)             state_nx = DONE;
      STORE:   if (push) state_nx = NEXT;
      NEXT:    state_nx = (idx + 4'd1 == blen) ? DONE : FETCH;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Control outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      sr              <= '0;
      wcnt            <= '0;
      bcnt            <= '0;
      tcnt            <= '0;
      blen            <= '0;
      idx             <= '0;
      hold            <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      cnt             <= '0;
      vec_ready_q     <= 1'b0;
      eng_start_q     <= 1'b0;
      eng_din_valid_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state           <= state_nx;
      vec_ready_q     <= (state_nx == FETCH);
      eng_start_q     <= (state_nx == START);
      eng_din_valid_q <= (state_nx inside {START, FEED, WAIT, STORE});
      busy_q          <= (state_nx != IDLE);
      done_q          <= (state_nx == DONE) ||
                         (state == IDLE && bus.cmd_start && bus.batch_len == '0);
      case (state)
        IDLE: if (bus.cmd_start && bus.batch_len != '0) begin
          blen  <= bus.batch_len;
          idx   <= '0;
          err_q <= 1'b0;
          wcnt  <= '0;
        end
        FETCH: if (accept) begin
          sr[int'(wcnt)*WORD_W +: WORD_W] <= bus.vec_word;
          wcnt <= last_word ? '0 : wcnt + 1'b1;
        end
        FEED: begin
          tcnt <= '0;
          if (shift) begin
            sr   <= sr >> 1;
            bcnt <= last_bit ? '0 : bcnt + 1'b1;
          end
        end
        WAIT: begin
          if (bus.eng_output_valid) hold  <= {idx, bus.eng_hw_digit};
          else if (tmo)             err_q <= 1'b1;
          else                      tcnt  <= tcnt + 1'b1;
        end
        NEXT:    idx <= idx + 4'd1;
        default: ;
      endcase
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= hold;
  end

  assign head = fifo_empty ? 8'h00 : mem[rd_ptr];

  assign bus.vec_ready     = vec_ready_q;
  assign bus.eng_start     = eng_start_q;
  assign bus.eng_din       = sr[0];
  assign bus.eng_din_valid = eng_din_valid_q;
  assign bus.res_idx       = head[7:4];
  assign bus.res_digit     = head[3:0];
  assign bus.res_valid     = !fifo_empty;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.err_timeout   = err_q;
endmodule

// File: tb/tb_elm_batch_sequencer.sv
// Randomised scoreboard bench for elm_batch_sequencer: host, engine and
// result-monitor processes checked against a vector-level reference model.
module tb_elm_batch_sequencer;
  localparam int VEC_BITS  = 256;
  localparam int WORD_W    = 16;
  localparam int RES_DEPTH = 8;
  localparam int TIMEOUT   = 100;
  localparam int NWORDS    = VEC_BITS / WORD_W;
  localparam int unsigned NONE = 99;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  elm_batch_sequencer_if #(.WORD_W(WORD_W)) bus();

  elm_batch_sequencer #(
    .VEC_BITS(VEC_BITS), .WORD_W(WORD_W), .RES_DEPTH(RES_DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int unsigned         n_applied = 0;
  int unsigned         n_bad     = 0;
  int unsigned         n_done    = 0;
  int unsigned         rr_mode   = 2;   // 0 hold low, 1 random, 2 always ready
  int unsigned         give_mode = 0;   // 0 random, 1 every other cycle, 2 always
  logic [7:0]          sb[$];
  logic [VEC_BITS-1:0] vecs[16];

  task automatic check(input string name, input logic [VEC_BITS-1:0] act,
                       input logic [VEC_BITS-1:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expired(input string name);
    n_applied++;
    n_bad++;
    $display("FAIL %s: got expired wait, expected DUT event", name);
  endtask

  // Reference digit the modelled engine reports: 7 * popcount, mod 10.
  function automatic logic [3:0] ref_digit(input logic [VEC_BITS-1:0] v);
    int unsigned ones = 0;
    for (int unsigned i = 0; i < VEC_BITS; i++) if (v[i]) ones++;
    return 4'((ones * 7) % 10);
  endfunction

  function automatic logic [15:0] all_outs();
    return {bus.vec_ready, bus.eng_start, bus.eng_din, bus.eng_din_valid,
            bus.res_valid, bus.busy, bus.done, bus.err_timeout,
            bus.res_digit, bus.res_idx};
  endfunction

  task automatic fill_random(input int unsigned len);
    for (int unsigned i = 0; i < len; i++)
      for (int unsigned w = 0; w < VEC_BITS / 32; w++) vecs[i][w*32 +: 32] = $urandom;
  endtask

  always @(negedge clk) if (bus.done === 1'b1) n_done++;

  // Result monitor: decides res_ready for the coming edge, then pops the scoreboard.
  initial begin
    bus.res_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rr_mode)
        0:       bus.res_ready = 1'b0;
        1:       bus.res_ready = 1'($urandom_range(0, 1));
        default: bus.res_ready = 1'b1;
      endcase
      if (rst && bus.res_valid && bus.res_ready) begin
        if (sb.size() == 0) begin
          n_applied++;
          n_bad++;
          $display("FAIL unexpected_result: got idx %0d digit %0d, expected no result",
                   bus.res_idx, bus.res_digit);
        end else begin
          logic [7:0] exp;
          exp = sb.pop_front();
          check("result", {bus.res_idx, bus.res_digit}, exp);
        end
      end
    end
  end

  task automatic host(input int unsigned len, input int unsigned no_resp_vec);
    for (int unsigned v = 0; v < len; v++) begin
      int unsigned k = 0, budget = 0;
      while (k < NWORDS) begin
        @(negedge clk);
        if (!bus.busy || !rst) begin bus.vec_valid = 1'b0; return; end
        if (bus.vec_ready && $urandom_range(0, 3) != 0) begin
          bus.vec_valid = 1'b1;
          bus.vec_word  = vecs[v][k*WORD_W +: WORD_W];
          k++;
        end else begin
          bus.vec_valid = 1'b0;
          bus.vec_word  = WORD_W'($urandom);
        end
        if (++budget > 5000) begin expired("host_words"); bus.vec_valid = 1'b0; return; end
      end
      if (v != no_resp_vec) sb.push_back({4'(v), ref_digit(vecs[v])});
      @(negedge clk);
      bus.vec_valid = 1'b0;
      check("start_latency", bus.eng_start, 1);
    end
  endtask

  task automatic engine(input int unsigned len, input int unsigned no_resp_vec,
                        input int unsigned rst_vec, input int unsigned stall_vec,
                        input int unsigned ign_vec);
    for (int unsigned v = 0; v < len; v++) begin
      logic [VEC_BITS-1:0] rx;
      int unsigned n, cyc, k;
      logic g, was_empty;
      rx = '0; n = 0; cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
        if (!bus.busy) return;
      end while (!bus.eng_start && cyc < 5000);
      check("eng_start_seen", bus.eng_start, 1);
      if (!bus.eng_start) return;
      check("din_valid_start", bus.eng_din_valid, 1);
      cyc = 0;
      while (n < VEC_BITS) begin
        @(negedge clk);
        cyc++;
        case (give_mode)
          1:       g = cyc[0];
          2:       g = 1'b1;
          default: g = 1'($urandom_range(0, 1));
        endcase
        bus.eng_give_input = g;
        if (g) begin rx[n] = bus.eng_din; n++; end
        // spurious engine result and command while feeding: both must be ignored
        bus.eng_output_valid = (n == 10);
        bus.eng_hw_digit     = 4'($urandom);
        bus.cmd_start        = (v == ign_vec) && (n == 100);
        bus.batch_len        = 4'($urandom_range(1, 15));
        if (v == rst_vec && n == 50) begin
          @(posedge clk);
          #2;
          rst = 1'b0;
          sb.delete();
          bus.eng_give_input = 1'b0; bus.eng_output_valid = 1'b0;
          bus.cmd_start = 1'b0; bus.vec_valid = 1'b0;
          #1 check("outputs_in_reset", all_outs(), 0);
          repeat (3) @(negedge clk);
          check("outputs_held_reset", all_outs(), 0);
          rst = 1'b1;
          return;
        end
      end
      @(negedge clk);
      bus.eng_give_input = 1'b0; bus.eng_output_valid = 1'b0; bus.cmd_start = 1'b0;
      check("rx_vector", rx, vecs[v]);
      if (v == no_resp_vec) begin
        k = 1;
        while (!bus.err_timeout && k < TIMEOUT + 20) begin @(negedge clk); k++; end
        check("timeout_cycle", k, TIMEOUT + 1);
        return;
      end
      repeat ($urandom_range(0, 20)) @(negedge clk);
      bus.eng_hw_digit     = ref_digit(rx);
      bus.eng_output_valid = 1'b1;
      was_empty            = !bus.res_valid;
      @(negedge clk);
      bus.eng_output_valid = 1'b0;
      bus.eng_hw_digit     = 4'($urandom);
      if (was_empty) check("res_latency_1", bus.res_valid, 0);
      @(negedge clk);
      if (was_empty) check("res_latency_2", bus.res_valid, 1);
      if (v == stall_vec) begin
        repeat (30) @(negedge clk);
        check("stall_busy", bus.busy, 1);
        check("stall_in_store", bus.eng_din_valid, 1);
        check("stall_no_fetch", bus.vec_ready, 0);
        check("stall_res_valid", bus.res_valid, 1);
        check("stall_pending", sb.size(), v + 1);
        rr_mode = 1;
      end
    end
  endtask

  task automatic run_batch(input int unsigned len, input int unsigned no_resp_vec,
                           input int unsigned rst_vec, input int unsigned stall_vec,
                           input int unsigned ign_vec);
    int unsigned d0, budget;
    d0 = n_done;
    @(negedge clk);
    bus.cmd_start = 1'b1;
    bus.batch_len = 4'(len);
    @(negedge clk);
    bus.cmd_start = 1'b0;
    bus.batch_len = 4'($urandom);
    check("busy_after_start", bus.busy, 1);
    fork
      host(len, no_resp_vec);
      engine(len, no_resp_vec, rst_vec, stall_vec, ign_vec);
    join
    if (rst_vec < len) begin
      @(negedge clk);
      check("no_done_after_reset", n_done - d0, 0);
      check("idle_after_reset", all_outs(), 0);
      check("sb_after_reset", sb.size(), 0);
      return;
    end
    budget = 0;
    while (n_done == d0 && budget < 5000) begin @(negedge clk); budget++; end
    check("done_count", n_done - d0, 1);
    @(negedge clk);
    check("idle_after_done", {bus.busy, bus.done, bus.vec_ready, bus.eng_din_valid}, 0);
    check("err_timeout", bus.err_timeout, (no_resp_vec < len) ? 1 : 0);
    budget = 0;
    while ((sb.size() != 0 || bus.res_valid) && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    check("drained_sb", sb.size(), 0);
    check("fifo_empty", bus.res_valid, 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got time limit, expected completion");
    $fatal(1);
  end

  initial begin
    bus.cmd_start = 1'b0; bus.batch_len = '0; bus.vec_word = '0; bus.vec_valid = 1'b0;
    bus.eng_give_input = 1'b0; bus.eng_hw_digit = '0; bus.eng_output_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 0);
    rst = 1'b1;

    // zero-length batch: done only
    @(negedge clk);
    bus.cmd_start = 1'b1; bus.batch_len = 4'd0;
    @(negedge clk);
    bus.cmd_start = 1'b0;
    check("zero_len_done", bus.done, 1);
    check("zero_len_quiet", {bus.busy, bus.vec_ready}, 0);
    @(negedge clk);
    check("zero_len_done_once", {bus.done, bus.busy, bus.vec_ready}, 0);

    // single vector 0x0001,0x0000,... -> digit 7
    vecs[0] = '0;
    vecs[0][0] = 1'b1;
    rr_mode = 1; give_mode = 0;
    run_batch(1, NONE, NONE, NONE, NONE);

    // toggling give_input, stray cmd_start during vector 1
    fill_random(3); give_mode = 1; rr_mode = 2;
    run_batch(3, NONE, NONE, NONE, 1);

    // host never pops: FIFO fills, 9th result stalls in STORE
    fill_random(10); give_mode = 2; rr_mode = 0;
    run_batch(10, NONE, NONE, 8, NONE);

    // engine silent on first vector
    fill_random(3); give_mode = 0; rr_mode = 1;
    run_batch(3, 0, NONE, NONE, NONE);

    repeat (3) begin
      int unsigned l;
      l = $urandom_range(1, 4);
      fill_random(l);
      give_mode = $urandom_range(0, 2);
      rr_mode   = $urandom_range(1, 2);
      run_batch(l, NONE, NONE, NONE, NONE);
    end

    // reset while feeding vector index 1, then a normal batch
    fill_random(3); give_mode = 0; rr_mode = 1;
    run_batch(3, NONE, 1, NONE, NONE);
    fill_random(1);
    run_batch(1, NONE, NONE, NONE, NONE);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_bad);
    $finish;
  end
endmodule

// File: doc/elm_batch_sequencer.md
ELM_BATCH_SEQUENCER -- requirements
Module: elm_batch_sequencer

Interface
REQ-001 Parameters (name, default, meaning), one per line: VEC_BITS 256 test-vector length; WORD_W 16 host word width; RES_DEPTH 8 result FIFO depth; TIMEOUT 65535 max cycles waiting for an engine result.
REQ-002 Ports (name direction width meaning), one per line:
clk in 1 single clock; all logic on rising edge.
rst in 1 asynchronous, active-low reset.
cmd_start in 1 one-cycle pulse starting a batch.
batch_len in 4 vectors in the batch, sampled with cmd_start.
vec_word in WORD_W host vector word.
vec_valid in 1 vec_word valid.
vec_ready out 1 sequencer accepts vec_word.
eng_start out 1 start pulse to inference engine.
eng_din out 1 serial vector bit to engine.
eng_din_valid out 1 test data available to engine.
eng_give_input in 1 engine requests one input bit this cycle.
eng_hw_digit in 4 engine predicted digit.
eng_output_valid in 1 eng_hw_digit valid.
res_digit out 4 result FIFO head digit.
res_idx out 4 vector index of head result.
res_valid out 1 FIFO non-empty.
res_ready in 1 host pops head.
busy out 1 batch in progress.
done out 1 one-cycle batch-complete pulse.
err_timeout out 1 sticky engine-timeout flag.

Function
REQ-003 FSM states SHALL be IDLE, FETCH, START, FEED, WAIT, STORE, NEXT, DONE.
REQ-004 IDLE: cmd_start with batch_len!=0 SHALL latch batch_len, clear vector index and err_timeout, go FETCH; cmd_start with batch_len==0 SHALL pulse done next cycle, no other effect; cmd_start outside IDLE SHALL be ignored.
REQ-005 FETCH: vec_ready=1; each vec_valid&vec_ready cycle SHALL load word k into shift-register bits [16k+15:16k]; after VEC_BITS/WORD_W (16) words go START.
REQ-006 START: eng_start=1 for exactly one cycle, then FEED.
REQ-007 eng_din_valid SHALL be 1 from START through STORE of every vector, 0 in IDLE, FETCH, NEXT, DONE.
REQ-008 FEED: eng_din SHALL equal shift-register bit 0 combinationally; each cycle with eng_give_input=1 SHALL shift right one bit and increment bit counter; deasserted eng_give_input SHALL stall without loss; after 256 shifts go WAIT.
REQ-009 WAIT: eng_output_valid=1 SHALL capture eng_hw_digit and current index into a holding register, go STORE; eng_output_valid in any other state SHALL be ignored.
REQ-010 WAIT timeout: counter cleared on WAIT entry; at TIMEOUT cycles without eng_output_valid SHALL set err_timeout, abort remaining vectors, go DONE.
REQ-011 STORE: write holding register into result FIFO when not full, then NEXT; FIFO full SHALL stall STORE until space.
REQ-012 Result FIFO: RES_DEPTH entries {idx,digit}; pop on res_valid&res_ready; simultaneous push and pop on full or empty SHALL both succeed; res_digit/res_idx SHALL show head, 0 when empty.
REQ-013 NEXT: increment index; index==batch_len SHALL go DONE, else FETCH.
REQ-014 DONE: done=1 for one cycle, then IDLE; FIFO contents SHALL persist into IDLE.
REQ-015 busy SHALL be 1 in every state except IDLE.
REQ-016 Latency: vector's last word accepted to eng_start = 1 cycle; eng_output_valid to res_valid (FIFO empty, not full) = 2 cycles.

Reset
REQ-017 rst low SHALL immediately set IDLE, clear FIFO, counters, shift register; outputs: vec_ready, eng_start, eng_din, eng_din_valid, res_valid, busy, done, err_timeout = 0; res_digit, res_idx = 0.
REQ-018 rst low mid-batch SHALL abandon the batch with no done pulse; operation resumes only on a new cmd_start after rst returns high.

Verification
REQ-019 batch_len=1, 16 words 0x0001,0x0000... with engine returning digit 7 -> eng_din=1 on first give_input cycle then 0 for 255, res_digit=7, res_idx=0, done pulse once.
REQ-020 batch_len=3, engine give_input toggling every other cycle -> exactly 256 bits per vector in order, res_idx 0,1,2 popped in order.
REQ-021 batch_len=10, res_ready=0 throughout -> 8 results stored, FSM stalls in STORE at 9th, resumes after pops, all 10 results delivered.
REQ-022 TIMEOUT=100, engine never asserts output_valid -> err_timeout=1 at cycle 100 of WAIT, done pulse, busy=0, no FIFO write.
REQ-023 rst low during FEED of vector 2 -> all outputs 0 next evaluation, FIFO empty, no done pulse; new cmd_start batch_len=1 completes normally.
REQ-024 cmd_start with batch_len=0 -> done pulse, no vec_ready; cmd_start during FEED -> ignored.
